cfg_bank: RTL

- Parametrised, single-clock configuration register bank for the DMA engine.
- Holds a per-channel queue mask, host-done and interrupt register set for N_CHAN channels.
- Includes an indirect AXI access sequencer with timeout and status reporting.
- Host writes and reads arrive over the split hi/lo 32-bit memory interface. Register outputs are consumed by CDC stages outside this block.

---
 rtl/cfg_bank.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cfg_bank.sv
// cfg_bank: per-channel DMA ring/interrupt configuration registers
// plus an indirect AXI access sequencer with timeout and status.
module cfg_bank #(
    parameter int          N_CHAN    = 4,
    parameter int          ADDR_BITS = 12,
    parameter logic [63:0] RST_MASK  = 64'h3ff,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_mem_valid,
    input  logic [ADDR_BITS-1:0]   wr_addr_lo,
    input  logic [ADDR_BITS-1:0]   wr_addr_hi,
    input  logic [31:0]            wr_data_lo,
    input  logic [31:0]            wr_data_hi,
    input  logic [3:0]             wr_mask_lo,
    input  logic [3:0]             wr_mask_hi,
    input  logic                   wr_en_lo,
    input  logic                   wr_en_hi,
    input  logic                   rd_mem_valid,
    input  logic [ADDR_BITS-1:0]   rd_addr_lo,
    input  logic [ADDR_BITS-1:0]   rd_addr_hi,
    input  logic                   rd_en_lo,
    input  logic                   rd_en_hi,
    output logic [31:0]            rd_data_lo,
    output logic [31:0]            rd_data_hi,
    output logic [N_CHAN*64-1:0]   dsc_mask,
    output logic [N_CHAN*64-1:0]   pkt_mask,
    output logic [N_CHAN*64-1:0]   dne_mask,
    output logic [N_CHAN*64-1:0]   host_dne_offset,
    output logic [N_CHAN*64-1:0]   host_dne_mask,
    output logic [N_CHAN-1:0]      int_enable,
    output logic [N_CHAN*16-1:0]   byte_wait,
    output logic                   soft_reset,
    output logic [31:0]            axi_rdwr_addr,
    output logic [31:0]            axi_wr_data,
    output logic                   axi_wr_go,
    output logic                   axi_rd_go,
    input  logic                   axi_wr_done,
    input  logic                   axi_rd_done,
    input  logic [31:0]            axi_rd_data,
    input  logic                   axi_error,
    output logic                   mem_cfg_rd_valid
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    localparam int IDX_SOFT = 256;
    localparam int IDX_WR   = 257;
    localparam int IDX_RD   = 258;
    localparam int IDX_RES  = 259;
    localparam int IDX_STS  = 260;

    typedef enum logic [1:0] {
        IDLE,
        WR_BUSY,
        RD_BUSY
    } state_t;

    logic [63:0] dsc_q  [N_CHAN];
    logic [63:0] pkt_q  [N_CHAN];
    logic [63:0] dne_q  [N_CHAN];
    logic [63:0] hoff_q [N_CHAN];
    logic [63:0] hmsk_q [N_CHAN];
    logic [15:0] bw_q   [N_CHAN];
    logic [N_CHAN-1:0] ie_q;

    logic        soft_q;
    logic [31:0] stage_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_q;
    logic [31:0] res_q, res_d;
    logic [3:1]  sts_q;
    logic        rdv_q, rdv_d;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic lo_we, hi_we;
    int   lo_idx, hi_idx;
    logic go_wr, go_rd;
    logic latch, done;
    logic set_err, set_to, set_ovf;
    logic [3:1] clr;
    logic unused_addr_bits;

    assign lo_we  = wr_mem_valid && wr_en_lo;
    assign hi_we  = wr_mem_valid && wr_en_hi;
    assign lo_idx = int'(wr_addr_lo[ADDR_BITS-1:3]);
    assign hi_idx = int'(wr_addr_hi[ADDR_BITS-1:3]);
    assign go_wr  = hi_we && hi_idx == IDX_WR && wr_mask_hi[3];
    assign go_rd  = hi_we && hi_idx == IDX_RD && wr_mask_hi[3];

    assign unused_addr_bits = ^{wr_addr_lo[2:0], wr_addr_hi[2:0],
                                rd_addr_lo[2:0], rd_addr_hi[2:0]};

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  m
    );
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
        return v;
    endfunction

    function automatic logic [31:0] wr_lo(input logic [31:0] old, input int key);
        return (lo_we && lo_idx == key) ? merge(old, wr_data_lo, wr_mask_lo) : old;
    endfunction

    function automatic logic [31:0] wr_hi(input logic [31:0] old, input int key);
        return (hi_we && hi_idx == key) ? merge(old, wr_data_hi, wr_mask_hi) : old;
    endfunction

    function automatic logic [63:0] wr64(input logic [63:0] old, input int key);
        return {wr_hi(old[63:32], key), wr_lo(old[31:0], key)};
    endfunction

    function automatic logic [31:0] rd_word(input int idx, input logic hi);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (idx == c*8 + 0) v = dsc_q[c];
            if (idx == c*8 + 1) v = pkt_q[c];
            if (idx == c*8 + 2) v = dne_q[c];
            if (idx == c*8 + 3) v = hoff_q[c];
            if (idx == c*8 + 4) v = hmsk_q[c];
            if (idx == c*8 + 5) v = {32'h0, bw_q[c], 15'h0, ie_q[c]};
        end
        if (idx == IDX_SOFT) v = {63'h0, soft_q};
        if (idx == IDX_WR)   v = {addr_q, stage_q};
        if (idx == IDX_RD)   v = {addr_q, 32'h0};
        if (idx == IDX_RES)  v = {32'h0, res_q};
        if (idx == IDX_STS)  v = {32'h0, 28'h0, sts_q, state_q != IDLE};
        return hi ? v[63:32] : v[31:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CHAN; c++) begin
                dsc_q[c]  <= RST_MASK;
                pkt_q[c]  <= RST_MASK;
                dne_q[c]  <= RST_MASK;
                hoff_q[c] <= '0;
                hmsk_q[c] <= '0;
                bw_q[c]   <= 16'hffff;
            end
            ie_q    <= '1;
            soft_q  <= 1'b0;
            stage_q <= '0;
        end else begin
            for (int c = 0; c < N_CHAN; c++) begin
                dsc_q[c]  <= wr64(dsc_q[c],  c*8 + 0);
                pkt_q[c]  <= wr64(pkt_q[c],  c*8 + 1);
                dne_q[c]  <= wr64(dne_q[c],  c*8 + 2);
                hoff_q[c] <= wr64(hoff_q[c], c*8 + 3);
                hmsk_q[c] <= wr64(hmsk_q[c], c*8 + 4);
                if (lo_we && lo_idx == c*8 + 5) begin
                    if (wr_mask_lo[0]) ie_q[c]       <= wr_data_lo[0];
                    if (wr_mask_lo[2]) bw_q[c][7:0]  <= wr_data_lo[23:16];
                    if (wr_mask_lo[3]) bw_q[c][15:8] <= wr_data_lo[31:24];
                end
            end
            if (lo_we && lo_idx == IDX_SOFT && wr_mask_lo[0])
                soft_q <= wr_data_lo[0];
            stage_q <= wr_lo(stage_q, IDX_WR);
        end
    end

    always_comb begin
        done = (state_q == WR_BUSY) ? axi_wr_done : axi_rd_done;
        clr  = (lo_we && lo_idx == IDX_STS && wr_mask_lo[0]) ? wr_data_lo[3:1] : 3'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        res_d   = res_q;
        rdv_d   = rdv_q;
        latch   = 1'b0;
        set_err = 1'b0;
        set_to  = 1'b0;
        set_ovf = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (go_wr) begin
                    state_d = WR_BUSY;
                    latch   = 1'b1;
                end else if (go_rd) begin
                    state_d = RD_BUSY;
                    latch   = 1'b1;
                    rdv_d   = 1'b0;
                    res_d   = 32'hdeadbeef;
                end
            end
            WR_BUSY, RD_BUSY: begin
                set_ovf = go_wr || go_rd;
                set_err = axi_error;
                // completion outranks a coincident error; the error stays flagged
                if (done) begin
                    state_d = IDLE;
                    rdv_d   = 1'b1;
                    if (state_q == RD_BUSY) res_d = axi_rd_data;
                end else if (axi_error) begin
                    state_d = IDLE;
                    rdv_d   = 1'b1;
                    res_d   = 32'hdeadbeef;
                end else if (cnt_q == T_LAST) begin
                    state_d = IDLE;
                    rdv_d   = 1'b1;
                    res_d   = 32'hdeadbeef;
                    set_to  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= 32'hcafebabe;
            rdv_q   <= 1'b1;
            sts_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rdv_q   <= rdv_d;
            sts_q   <= (sts_q & ~clr) | {set_ovf, set_to, set_err};
            if (latch) begin
                addr_q <= wr_data_hi;
                if (go_wr) wdata_q <= wr_lo(stage_q, IDX_WR);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_lo <= '0;
            rd_data_hi <= '0;
        end else begin
            if (rd_mem_valid && rd_en_lo)
                rd_data_lo <= rd_word(int'(rd_addr_lo[ADDR_BITS-1:3]), 1'b0);
            if (rd_mem_valid && rd_en_hi)
                rd_data_hi <= rd_word(int'(rd_addr_hi[ADDR_BITS-1:3]), 1'b1);
        end
    end

    for (genvar c = 0; c < N_CHAN; c++) begin : g_out
        assign dsc_mask[c*64 +: 64]        = dsc_q[c];
        assign pkt_mask[c*64 +: 64]        = pkt_q[c];
        assign dne_mask[c*64 +: 64]        = dne_q[c];
        assign host_dne_offset[c*64 +: 64] = hoff_q[c];
        assign host_dne_mask[c*64 +: 64]   = hmsk_q[c];
        assign byte_wait[c*16 +: 16]       = bw_q[c];
    end

    assign int_enable       = ie_q;
    assign soft_reset       = soft_q;
    assign axi_rdwr_addr    = addr_q;
    assign axi_wr_data      = wdata_q;
    assign axi_wr_go        = state_q == WR_BUSY;
    assign axi_rd_go        = state_q == RD_BUSY;
    assign mem_cfg_rd_valid = rdv_q;

endmodule
